// File: rtl/u_bam_dot_accumulator.sv
// u_bam_dot_accumulator: saturating dot-product accumulator for broken-array multiplier products
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset, discards any partial or pending result
//   in_valid_i   in_prod_i / in_last_i are valid this cycle
//   in_ready_o   block accepts a product this cycle (ACCUM state)
//   in_prod_i    unsigned product from the multiplier
//   in_last_i    this beat closes the current vector
//   out_valid_o  result is held on out_acc_o / out_count_o / out_sat_o (HOLD state)
//   out_ready_i  downstream consumes the result this cycle
//   out_acc_o    accumulated sum, saturated to all-ones
//   out_count_o  number of products in the vector
//   out_sat_o    saturation occurred at least once in the vector
module u_bam_dot_accumulator #(
    parameter int PROD_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int MAX_TERMS  = 256,
    parameter int CNT_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [PROD_WIDTH-1:0] in_prod_i,
    input  logic                  in_last_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ACC_WIDTH-1:0]  out_acc_o,
    output logic [CNT_WIDTH-1:0]  out_count_o,
    output logic                  out_sat_o
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    // One extra bit catches the carry out that signals saturation.
    logic [ACC_WIDTH:0]     sum;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    assign sum     = {1'b0, acc_q} + (ACC_WIDTH+1)'(in_prod_i);
    assign cnt_inc = cnt_q + 1'b1;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        if (state_q == ACCUM) begin
            if (in_valid_i) begin
                acc_d   = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
                sat_d   = sat_q | sum[ACC_WIDTH];
                cnt_d   = cnt_inc;
                state_d = (in_last_i || cnt_inc == CNT_WIDTH'(MAX_TERMS)) ? HOLD : ACCUM;
            end
        end else if (out_ready_i) begin
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            state_d = ACCUM;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end
    // Handshake flags are pure state decodes; result fields are gated to zero outside HOLD.
    assign in_ready_o  = (state_q == ACCUM);
    assign out_valid_o = (state_q == HOLD);
    assign out_acc_o   = out_valid_o ? acc_q : '0;
    assign out_count_o = out_valid_o ? cnt_q : '0;
    assign out_sat_o   = out_valid_o & sat_q;
endmodule

// File: tb/tb_u_bam_dot_accumulator.sv
// tb_u_bam_dot_accumulator: scoreboard bench for default, 16-bit-accumulator and 4-term-limit builds
module tb_u_bam_dot_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid[3], in_last[3], out_ready[3];
    logic [15:0] in_prod[3];
    logic        in_ready[3], out_valid[3], out_sat[3];
    logic [8:0]  out_count[3];
    logic [23:0] out_acc[3];
    logic [23:0] acc0, acc2;
    logic [15:0] acc1;
    int          tests = 0, failed = 0;
    int          aw[3] = '{24, 16, 24};
    int          mt[3] = '{256, 256, 4};
    logic [24:0] m_acc[3];
    int          m_cnt[3];
    logic        m_sat[3];
    logic [40:0] sb[3][$];
    logic        held[3];
    logic [23:0] p_acc[3];
    logic [8:0]  p_cnt[3];
    logic        p_sat[3];

    always #5 clk = ~clk;

    assign out_acc[0] = acc0;
    assign out_acc[1] = {8'h00, acc1};
    assign out_acc[2] = acc2;

    u_bam_dot_accumulator u0 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .in_prod_i(in_prod[0]), .in_last_i(in_last[0]), .out_valid_o(out_valid[0]),
        .out_ready_i(out_ready[0]), .out_acc_o(acc0), .out_count_o(out_count[0]), .out_sat_o(out_sat[0]));
    u_bam_dot_accumulator #(.ACC_WIDTH(16)) u1 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .in_prod_i(in_prod[1]), .in_last_i(in_last[1]), .out_valid_o(out_valid[1]),
        .out_ready_i(out_ready[1]), .out_acc_o(acc1), .out_count_o(out_count[1]), .out_sat_o(out_sat[1]));
    u_bam_dot_accumulator #(.MAX_TERMS(4)) u2 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .in_prod_i(in_prod[2]), .in_last_i(in_last[2]), .out_valid_o(out_valid[2]),
        .out_ready_i(out_ready[2]), .out_acc_o(acc2), .out_count_o(out_count[2]), .out_sat_o(out_sat[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++) begin
            m_acc[d] = '0;
            m_cnt[d] = 0;
            m_sat[d] = 1'b0;
        end
    endtask

    // Holds one beat until the DUT takes it, then advances the reference model.
    task automatic send(input int d, input logic [15:0] p, input logic l);
        int n = 0;
        logic ok = 1'b0;
        logic [24:0] s, mx;
        in_valid[d] = 1'b1;
        in_prod[d]  = p;
        in_last[d]  = l;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready[d];
            @(posedge clk);
            #1;
            n++;
        end
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
        if (!ok) begin
            check($sformatf("accept_timeout%0d", d), 32'd0, 32'd1);
            return;
        end
        mx = (25'd1 << aw[d]) - 25'd1;
        s  = m_acc[d] + {9'd0, p};
        if (s > mx) begin
            m_acc[d] = mx;
            m_sat[d] = 1'b1;
        end else begin
            m_acc[d] = s;
        end
        m_cnt[d]++;
        if (l || m_cnt[d] == mt[d]) begin
            sb[d].push_back({m_sat[d], 16'(m_cnt[d]), m_acc[d][23:0]});
            m_acc[d] = '0;
            m_cnt[d] = 0;
            m_sat[d] = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", sb[0].size() + sb[1].size() + sb[2].size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) held[d] <= 1'b0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("in_ready%0d", d), in_ready[d], !out_valid[d]);
                if (out_valid[d]) begin
                    if (held[d]) begin
                        check($sformatf("stable_acc%0d", d), out_acc[d], p_acc[d]);
                        check($sformatf("stable_cnt%0d", d), out_count[d], p_cnt[d]);
                        check($sformatf("stable_sat%0d", d), out_sat[d], p_sat[d]);
                    end
                    if (out_ready[d]) begin
                        held[d] <= 1'b0;
                        if (sb[d].size() == 0) begin
                            check($sformatf("unexpected_result%0d", d), 32'd1, 32'd0);
                        end else begin
                            check($sformatf("acc%0d", d), out_acc[d], sb[d][0][23:0]);
                            check($sformatf("count%0d", d), out_count[d], 9'(sb[d][0][39:24]));
                            check($sformatf("sat%0d", d), out_sat[d], sb[d][0][40]);
                            sb[d].pop_front();
                        end
                    end else begin
                        held[d]  <= 1'b1;
                        p_acc[d] <= out_acc[d];
                        p_cnt[d] <= out_count[d];
                        p_sat[d] <= out_sat[d];
                    end
                end else begin
                    if (held[d]) check($sformatf("hold_dropped%0d", d), 32'd0, 32'd1);
                    held[d] <= 1'b0;
                    check($sformatf("idle_zero%0d", d), {out_sat[d], out_count[d], out_acc[d]}, 0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_last[d]   = 1'b0;
            in_prod[d]   = '0;
            out_ready[d] = 1'b1;
        end
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_valid%0d", d), out_valid[d], 1'b0);
            check($sformatf("rst_ready%0d", d), in_ready[d], 1'b1);
        end
        @(posedge clk);
        #1;
        send(0, 16'h7C00, 1'b1);
        send(0, 16'h0400, 1'b0);
        send(0, 16'h1C00, 1'b0);
        send(0, 16'hFC00, 1'b1);
        send(0, 16'h0000, 1'b0);
        send(0, 16'h0000, 1'b0);
        send(0, 16'h0005, 1'b1);
        send(1, 16'hF000, 1'b0);
        send(1, 16'h2000, 1'b1);
        send(1, 16'h0001, 1'b1);
        send(1, 16'hFFFF, 1'b1);
        send(1, 16'hF000, 1'b0);
        send(1, 16'h2000, 1'b0);
        send(1, 16'h0001, 1'b1);
        for (int i = 0; i < 6; i++) send(2, 16'h0100, 1'b0);
        send(2, 16'h0100, 1'b1);
        for (int i = 0; i < 4; i++) send(2, 16'h0010, i == 3);
        send(0, 16'h1111, 1'b1);
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_prod[0]   = 16'h1234;
        in_last[0]   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        send(0, 16'h1234, 1'b1);
        drain();
        send(0, 16'h0100, 1'b0);
        send(0, 16'h0200, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        check("post_rst_valid", out_valid[0], 1'b0);
        @(posedge clk);
        #1;
        send(0, 16'h0400, 1'b1);
        drain();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
